uart_rx_unit: RTL and testbench

//   Asynchronous serial receiver (UART RX) with a programmable baud divider, 5-8 data bits and optional even parity.
//   It deserialises frames from the rx_i line and presents bytes over a valid/ready handshake.
//   It sits beside the SoC top's uart_tx output and prints the characters the core writes in the system bench.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_sync.sv | 31 +++
 rtl/uart_rx_unit.sv | 115 +++++++++++
 tb/tb_uart_rx_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver: FSM state encoding and
// data-width decoding of the cfg_bits field.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [1:0] BITS_5 = 2'b00;
  localparam logic [1:0] BITS_6 = 2'b01;
  localparam logic [1:0] BITS_7 = 2'b10;
  localparam logic [1:0] BITS_8 = 2'b11;

  function automatic logic [3:0] nbits(input logic [1:0] cfg_bits);
    case (cfg_bits)
      BITS_5:  nbits = 4'd5;
      BITS_6:  nbits = 4'd6;
      BITS_7:  nbits = 4'd7;
      BITS_8:  nbits = 4'd8;
      default: nbits = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Brings the asynchronous rx line into the clk_i domain and flags falling edges.
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  output logic rx_sync,
  output logic fall_edge
);

  logic s1, s2, s3;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= rx_i;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // The edge is seen one cycle ahead of the sampled bit, so the FSM can enter
  // START exactly when the start bit reaches rx_sync (needed for 1 clk/bit).
  assign rx_sync   = s3;
  assign fall_edge = s3 & ~s2;

endmodule

// File: rtl/uart_rx_unit.sv
// UART receiver: programmable bit period, 5-8 data bits, optional even parity,
// byte output over a valid/ready handshake with a sticky parity-error flag.
module uart_rx_unit
  import uart_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_i,
  input  logic        cfg_en_i,
  input  logic [15:0] cfg_div_i,
  input  logic        cfg_parity_en_i,
  input  logic [1:0]  cfg_bits_i,
  output logic        busy_o,
  output logic        err_o,
  input  logic        err_clr_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i
);

  logic        rx_sync, fall_edge;
  state_t      state, state_n;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        half_hit, full_hit, last_bit;
  logic        data_smp, par_smp, deliver;

  uart_rx_sync u_sync (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .rx_i      (rx_i),
    .rx_sync   (rx_sync),
    .fall_edge (fall_edge)
  );

  assign half_hit = (cnt == (cfg_div_i >> 1));
  assign full_hit = (cnt == cfg_div_i);
  assign last_bit = ({1'b0, bit_idx} == nbits(cfg_bits_i) - 4'd1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_n  = state;
    data_smp = 1'b0;
    par_smp  = 1'b0;
    deliver  = 1'b0;
    case (state)
      IDLE:   if (cfg_en_i && fall_edge) state_n = START;
      START:  if (half_hit) state_n = rx_sync ? IDLE : DATA;
      DATA:   if (full_hit) begin
                data_smp = 1'b1;
                if (last_bit) state_n = cfg_parity_en_i ? PARITY : STOP;
              end
      PARITY: if (full_hit) begin
                par_smp = 1'b1;
                state_n = STOP;
              end
      // A start bit may already be arriving when the stop bit is sampled at
      // very short bit periods; chain straight into the next frame.
      STOP:   if (full_hit) begin
                deliver = 1'b1;
                state_n = (cfg_en_i && fall_edge) ? START : IDLE;
              end
      default: state_n = IDLE;
    endcase
    if (!cfg_en_i) begin
      state_n  = IDLE;
      data_smp = 1'b0;
      par_smp  = 1'b0;
      deliver  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      if (state == IDLE || state_n != state || data_smp) cnt <= '0;
      else                                                cnt <= cnt + 16'd1;

      // Clearing the shift register per frame keeps unused upper bits zero.
      if (state_n == START && state != START) begin
        bit_idx <= '0;
        shift   <= '0;
      end else if (data_smp) begin
        shift[bit_idx] <= rx_sync;
        bit_idx        <= bit_idx + 3'd1;
      end

      if (par_smp && ((^shift) ^ rx_sync)) err_o <= 1'b1;
      else if (err_clr_i)                  err_o <= 1'b0;

      if (deliver) begin
        rx_data_o  <= shift;
        rx_valid_o <= 1'b1;
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
    end
  end

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_unit.sv
// Self-checking bench for uart_rx_unit: vector table, directed corner cases
// and randomized frames compared against a frame-level reference model.
module tb_uart_rx_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx = 1'b1;
  logic        cfg_en = 1'b1;
  logic [15:0] cfg_div = 16'd7;
  logic        cfg_pe = 1'b0;
  logic [1:0]  cfg_bits = 2'b11;
  logic        err_clr = 1'b0;
  logic        ready = 1'b1;
  logic        busy, err, valid;
  logic [7:0]  data;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  uart_rx_unit dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .rx_i            (rx),
    .cfg_en_i        (cfg_en),
    .cfg_div_i       (cfg_div),
    .cfg_parity_en_i (cfg_pe),
    .cfg_bits_i      (cfg_bits),
    .busy_o          (busy),
    .err_o           (err),
    .err_clr_i       (err_clr),
    .rx_data_o       (data),
    .rx_valid_o      (valid),
    .rx_ready_i      (ready)
  );

  // Delivery monitor: records each newly presented byte and counts busy/valid cycles.
  logic [7:0] got_arr [0:255];
  int         got_wr = 0;
  int         rd_idx = 0;
  int         valid_cycles = 0;
  int         busy_cycles = 0;
  logic       last_valid = 1'b0;
  logic       last_acc = 1'b0;

  always @(negedge clk) begin
    if (valid && (!last_valid || last_acc)) begin
      got_arr[got_wr[7:0]] = data;
      got_wr++;
    end
    last_valid = valid;
    last_acc   = valid & ready;
    if (valid) valid_cycles++;
    if (busy)  busy_cycles++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic drive_bit(input logic v, input int div);
    rx = v;
    repeat (div + 1) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int n, input bit pe, input bit pb,
                            input int div);
    drive_bit(1'b0, div);
    for (int i = 0; i < n; i++) drive_bit(d[i], div);
    if (pe) drive_bit(pb, div);
    drive_bit(1'b1, div);
  endtask

  task automatic get_rx(input string name, input logic [7:0] exp, input int div);
    int limit;
    limit = 40 * (div + 1) + 50;
    for (int i = 0; i < limit && rd_idx == got_wr; i++) @(negedge clk);
    if (rd_idx == got_wr) begin
      n_total++;
      $display("FAIL %s: no byte delivered within %0d cycles, expected %0h", name, limit, exp);
    end else begin
      check(name, {24'd0, got_arr[rd_idx[7:0]]}, {24'd0, exp});
      rd_idx++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  typedef struct {
    logic [7:0] d;
    logic [1:0] bits;
    bit         pe;
    bit         pb;
    int         div;
    logic [7:0] exp_d;
    bit         exp_err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int base_b, base_v, n, exp2, diff;
    bit pe, pb;
    logic [7:0] d, exp_d;
    logic [15:0] divs[7];

    vecs[0] = '{8'h41, 2'b11, 1'b0, 1'b0, 7, 8'h41, 1'b0};
    vecs[1] = '{8'h03, 2'b11, 1'b1, 1'b0, 7, 8'h03, 1'b0};
    vecs[2] = '{8'h07, 2'b11, 1'b1, 1'b0, 7, 8'h07, 1'b1};
    vecs[3] = '{8'h15, 2'b00, 1'b0, 1'b0, 7, 8'h15, 1'b0};
    vecs[4] = '{8'hFF, 2'b00, 1'b0, 1'b0, 0, 8'h1F, 1'b0};
    vecs[5] = '{8'hC3, 2'b10, 1'b1, 1'b1, 7, 8'h43, 1'b0};
    vecs[6] = '{8'hAA, 2'b01, 1'b1, 1'b0, 2, 8'h2A, 1'b1};
    vecs[7] = '{8'h80, 2'b11, 1'b1, 1'b1, 7, 8'h80, 1'b0};
    divs = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd5, 16'd7, 16'd12};

    // Reset state
    #1 rst = 1'b1;
    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_data", {24'd0, data}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Vector table
    for (int k = 0; k < 8; k++) begin
      cfg_div  = 16'(vecs[k].div);
      cfg_bits = vecs[k].bits;
      cfg_pe   = vecs[k].pe;
      pulse_clr();
      base_b = busy_cycles;
      base_v = valid_cycles;
      n = int'(vecs[k].bits) + 5;
      send_frame(vecs[k].d, n, vecs[k].pe, vecs[k].pb, vecs[k].div);
      get_rx($sformatf("vec%0d_data", k), vecs[k].exp_d, vecs[k].div);
      check($sformatf("vec%0d_err", k), {31'd0, err}, {31'd0, vecs[k].exp_err});
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("vec%0d_valid_pulse", k), valid_cycles - base_v, 32'd1);
      // Busy spans start detection to the stop-bit sample: ~(bits + 1.5) periods.
      exp2 = (2 * (n + int'(vecs[k].pe)) + 3) * (vecs[k].div + 1);
      diff = 2 * (busy_cycles - base_b) - exp2;
      if (diff < 0) diff = -diff;
      check($sformatf("vec%0d_busy_len", k), {31'd0, diff <= vecs[k].div + 3}, 32'd1);
    end

    // Sticky parity error and clear
    cfg_div = 16'd7; cfg_bits = 2'b11; cfg_pe = 1'b1;
    pulse_clr();
    send_frame(8'h07, 8, 1'b1, 1'b0, 7);
    get_rx("sticky_data", 8'h07, 7);
    repeat (20) @(posedge clk);
    #1;
    check("sticky_err_held", {31'd0, err}, 32'd1);
    pulse_clr();
    check("sticky_err_cleared", {31'd0, err}, 32'd0);

    // Back-pressure: valid holds until one ready cycle
    cfg_pe = 1'b0;
    ready  = 1'b0;
    send_frame(8'h5A, 8, 1'b0, 1'b0, 7);
    get_rx("hold_data", 8'h5A, 7);
    base_v = valid_cycles;
    repeat (20) @(posedge clk);
    #1;
    check("hold_valid_cycles", valid_cycles - base_v, 32'd20);
    check("hold_valid_high", {31'd0, valid}, 32'd1);
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    check("hold_valid_dropped", {31'd0, valid}, 32'd0);
    ready = 1'b1;

    // Glitch on the line
    base_b = busy_cycles;
    rx = 1'b0;
    repeat (2) @(posedge clk);
    #1 rx = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("glitch_seen", {31'd0, (busy_cycles - base_b) > 0}, 32'd1);
    check("glitch_idle", {31'd0, busy}, 32'd0);
    check("glitch_no_rx", got_wr - rd_idx, 32'd0);

    // Reset mid-frame with valid and err both set beforehand
    ready = 1'b0; cfg_pe = 1'b1;
    send_frame(8'h07, 8, 1'b1, 1'b0, 7);
    get_rx("pre_rst_data", 8'h07, 7);
    check("pre_rst_err", {31'd0, err}, 32'd1);
    fork
      send_frame(8'h3C, 8, 1'b1, 1'b0, 7);
      begin
        repeat (30) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_valid", {31'd0, valid}, 32'd0);
        check("midrst_err", {31'd0, err}, 32'd0);
        check("midrst_data", {24'd0, data}, 32'd0);
      end
    join
    @(posedge clk);
    #1 rst = 1'b0;
    check("post_rst_no_rx", got_wr - rd_idx, 32'd0);
    rd_idx = got_wr;
    ready = 1'b1; cfg_pe = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 7);
    get_rx("post_rst_data", 8'hA5, 7);

    // One clock per bit, back-to-back frames
    cfg_div = 16'd0;
    send_frame(8'h00, 8, 1'b0, 1'b0, 0);
    send_frame(8'hFF, 8, 1'b0, 1'b0, 0);
    send_frame(8'h55, 8, 1'b0, 1'b0, 0);
    get_rx("b2b_0", 8'h00, 0);
    get_rx("b2b_1", 8'hFF, 0);
    get_rx("b2b_2", 8'h55, 0);

    // Randomized frames against the frame-level model
    for (int k = 0; k < 40; k++) begin
      cfg_div  = divs[$urandom_range(0, 6)];
      cfg_bits = 2'($urandom_range(0, 3));
      pe       = 1'($urandom_range(0, 1));
      cfg_pe   = pe;
      d        = 8'($urandom);
      n        = int'(cfg_bits) + 5;
      exp_d    = d & 8'((1 << n) - 1);
      pb       = ($urandom_range(0, 2) != 0) ? ^exp_d : 1'($urandom_range(0, 1));
      pulse_clr();
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send_frame(d, n, pe, pb, int'(cfg_div));
      get_rx($sformatf("rnd%0d_data", k), exp_d, int'(cfg_div));
      check($sformatf("rnd%0d_err", k), {31'd0, err}, {31'd0, pe & ((^exp_d) ^ pb)});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
